onehot2bin_stream: RTL and testbench
====================================

Name: onehot2bin_stream

Overview:
- Streaming one-hot to binary encoder. It is the inverse of the bin2onehot utility.
- Accepts one-hot vectors on a valid/ready input and emits the encoded binary index on a valid/ready output, with one register stage and a skid buffer.
- Checks every beat for a legal one-hot code and keeps a saturating count of illegal beats.
- Sits in front of decode and arbitration logic that produces one-hot grants and needs binary indices downstream.

Parameters:
- ONEHOT_WIDTH, 16, width of the one-hot input vector; legal range ≥1.
- BIN_WIDTH, (ONEHOT_WIDTH==1 ? 1 : $clog2(ONEHOT_WIDTH)), output index width; derived, do not override.
- ERR_CNT_WIDTH, 8, width of the saturating illegal-beat counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_onehot  input  ONEHOT_WIDTH  one-hot code to encode.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_bin  output  BIN_WIDTH  encoded index.
- out_err  output  1  the beat was not exactly one-hot.
- out_zero  output  1  the beat had no bit set; this implies out_err.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  ERR_CNT_WIDTH  saturating count of accepted illegal beats.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0; out_bin=0; out_err=0; out_zero=0; err_cnt=0.
  - Skid buffer is empty.
  - in_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Once out_valid=1, out_bin, out_err and out_zero are held stable until the output transfer.
- Encoding is combinational on in_onehot and is registered at input acceptance:
  - Exactly one bit i set: bin=i, err=0, zero=0.
  - No bit set: bin=0, err=1, zero=1.
  - More than one bit set: bin=index of the lowest set bit, err=1, zero=0.
- Datapath: an output register (main) plus a one-entry skid register.
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
  - Accept while the main register is empty, or full and out_ready=1: the beat goes to main.
  - Accept while main is full and out_ready=0: the beat goes to skid.
  - On an output transfer with skid full: skid moves to main and skid empties.
  - Simultaneous input and output transfers with skid empty: the new beat replaces main in the same cycle.
- Latency: 1 cycle from the input transfer to out_valid. Throughput is 1 beat/cycle when out_ready is held at 1.
- Ordering and integrity: beats leave in acceptance order, with no loss, duplication or reordering under any ready/valid pattern.
- Back-pressure: with out_ready=0, at most 2 beats are held (main + skid). in_ready drops to 0 the cycle after the second beat is accepted.
- Error counter:
  - Increments by 1 on each accepted beat with err=1.
  - Saturates at 2^ERR_CNT_WIDTH-1 and never wraps.
  - err_clr=1 clears the count. If err_clr coincides with an errored accept, the next err_cnt is 1.
  - Beats discarded by reset are not counted.
- ONEHOT_WIDTH==1: BIN_WIDTH=1 and out_bin is always 0. An input of 0 gives err=1, zero=1.
- Reset mid-operation: all held beats are discarded, out_valid=0 the next cycle, and err_cnt=0.
- Simulation only (`ifndef SYNTHESIS): assertions that out_bin/out_err/out_zero are stable while out_valid && !out_ready, and that out_zero implies out_err.

Test Plan:
- Legal single beats, W=16, out_ready=1: feed 0x0001, 0x0400, 0x8000. Required: out_bin = 0, 10, 15 one cycle later; out_err=0; err_cnt=0.
- Illegal beats: feed 0x0000, then 0x0120. Required:
  - First beat: bin=0, err=1, zero=1.
  - Second beat: bin=5, err=1, zero=0.
  - err_cnt=2.
- Back-pressure: out_ready=0 and 4 consecutive valid beats 0x1, 0x2, 0x4, 0x8. Required: only the first 2 are accepted and in_ready=0 after the second. Then release out_ready=1 and check outputs 0, 1, 2, 3 in order, with no loss.
- Random stall stress: 1000 random beats, random in_valid and out_ready. Required: the scoreboard matches exactly and output fields are stable while stalled.
- Counter: ERR_CNT_WIDTH=4 and 20 illegal beats. Required: err_cnt saturates at 15. Then assert err_clr together with one illegal accept: next err_cnt=1.
- Reset mid-stream: with 2 beats held, assert rst for 1 cycle. Required: out_valid=0 and err_cnt=0 the next cycle; in_ready=0 during rst and 1 after.

Source files
------------

// File: rtl/onehot2bin_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | onehot2bin_stream_if                                                     |
// | Valid/ready bus carrying one-hot beats in and encoded indices out.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface onehot2bin_stream_if #(
  parameter int ONEHOT_WIDTH = 16
);
  localparam int BIN_WIDTH = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [ONEHOT_WIDTH-1:0] in_onehot;
  logic                    out_valid;
  logic                    out_ready;
  logic [BIN_WIDTH-1:0]    out_bin;
  logic                    out_err;
  logic                    out_zero;

  // master: the environment feeding beats in and draining results
  modport master (
    output in_valid, in_onehot, out_ready,
    input  in_ready, out_valid, out_bin, out_err, out_zero
  );

  // slave: the encoder block itself
  modport slave (
    input  in_valid, in_onehot, out_ready,
    output in_ready, out_valid, out_bin, out_err, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/onehot2bin_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | onehot2bin_stream                                                        |
// | Streaming one-hot to binary encoder with skid buffer and error counter.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module onehot2bin_stream #(
  parameter int ONEHOT_WIDTH  = 16,
  parameter int BIN_WIDTH     = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH),
  parameter int ERR_CNT_WIDTH = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  onehot2bin_stream_if.slave            bus,
  input  wire logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt
);

  localparam logic [ERR_CNT_WIDTH-1:0] c_cnt_max = '1;

  logic [BIN_WIDTH-1:0]     w_bin;
  logic                     w_zero;
  logic                     w_multi;
  logic                     w_err;
  logic                     w_in_acc;
  logic                     w_out_xfer;

  logic                     r_main_valid;
  logic [BIN_WIDTH-1:0]     r_main_bin;
  logic                     r_main_err;
  logic                     r_main_zero;
  logic                     r_skid_valid;
  logic [BIN_WIDTH-1:0]     r_skid_bin;
  logic                     r_skid_err;
  logic                     r_skid_zero;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  // Descending scan so the lowest set bit is the last to win.
  always_comb begin
    w_bin = '0;
    for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
      if (bus.in_onehot[i]) begin
        w_bin = BIN_WIDTH'(i);
      end
    end
  end

  assign w_zero  = ~|bus.in_onehot;
  assign w_multi = |(bus.in_onehot & (bus.in_onehot - ONEHOT_WIDTH'(1)));
  assign w_err   = w_zero | w_multi;

  assign bus.in_ready  = !r_skid_valid && !rst;
  assign w_in_acc      = bus.in_valid && bus.in_ready;
  assign w_out_xfer    = r_main_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_bin   <= '0;
      r_main_err   <= 1'b0;
      r_main_zero  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_bin   <= '0;
      r_skid_err   <= 1'b0;
      r_skid_zero  <= 1'b0;
    end else if (w_out_xfer || !r_main_valid) begin
      // Main register is free this cycle: skid has priority to keep order.
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_bin   <= r_skid_bin;
        r_main_err   <= r_skid_err;
        r_main_zero  <= r_skid_zero;
        r_skid_valid <= 1'b0;
      end else if (w_in_acc) begin
        r_main_valid <= 1'b1;
        r_main_bin   <= w_bin;
        r_main_err   <= w_err;
        r_main_zero  <= w_zero;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_acc) begin
      r_skid_valid <= 1'b1;
      r_skid_bin   <= w_bin;
      r_skid_err   <= w_err;
      r_skid_zero  <= w_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= (w_in_acc && w_err) ? ERR_CNT_WIDTH'(1) : '0;
    end else if (w_in_acc && w_err && (r_err_cnt != c_cnt_max)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign bus.out_valid = r_main_valid;
  assign bus.out_bin   = r_main_bin;
  assign bus.out_err   = r_main_err;
  assign bus.out_zero  = r_main_zero;
  assign err_cnt       = r_err_cnt;

`ifndef SYNTHESIS
  a_stall_stable: assert property (
    @(posedge clk) disable iff (rst)
    (r_main_valid && !bus.out_ready) |=>
      ($stable(r_main_bin) && $stable(r_main_err) && $stable(r_main_zero))
  ) else $error("output fields changed while stalled");

  a_zero_implies_err: assert property (
    @(posedge clk) disable iff (rst)
    r_main_zero |-> r_main_err
  ) else $error("out_zero set without out_err");
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot2bin_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_onehot2bin_stream                                                     |
// | Scoreboard bench for the streaming one-hot to binary encoder.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_onehot2bin_stream;

  logic       clk;
  logic       rst;
  logic       err_clr;
  logic [3:0] err_cnt;
  logic       err_clr1;
  logic [7:0] err_cnt1;

  onehot2bin_stream_if #(.ONEHOT_WIDTH(16)) u_if ();
  onehot2bin_stream_if #(.ONEHOT_WIDTH(1))  u_if1 ();

  onehot2bin_stream #(.ONEHOT_WIDTH(16), .ERR_CNT_WIDTH(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (u_if.slave),
    .err_clr (err_clr),
    .err_cnt (err_cnt)
  );

  onehot2bin_stream #(.ONEHOT_WIDTH(1), .ERR_CNT_WIDTH(8)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (u_if1.slave),
    .err_clr (err_clr1),
    .err_cnt (err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errs   = 0;
  logic [5:0] q_exp[$];
  logic [3:0] m_cnt;
  logic       acc;
  logic       prev_stall;
  logic [5:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {zero, err, bin}: lowest set bit, error unless exactly one bit.
  function automatic logic [5:0] enc(input logic [15:0] v);
    int idx;
    idx = 0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = i;
    if (v == 16'h0) return 6'b11_0000;
    return {1'b0, ($countones(v) != 1), idx[3:0]};
  endfunction

  function automatic logic [5:0] obs_fields();
    return {u_if.out_zero, u_if.out_err, u_if.out_bin};
  endfunction

  // Inputs are set at the negedge before the call; transfers happen at the next posedge.
  task automatic cycle();
    logic       ox;
    logic [5:0] e;
    #1;
    acc = u_if.in_valid && u_if.in_ready;
    ox  = u_if.out_valid && u_if.out_ready;
    if (prev_stall) check("stall_stable", obs_fields(), held);
    if (ox) begin
      if (q_exp.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        e = q_exp.pop_front();
        check("beat", obs_fields(), e);
      end
    end
    if (acc) begin
      e = enc(u_if.in_onehot);
      q_exp.push_back(e);
      if (err_clr) m_cnt = e[4] ? 4'd1 : 4'd0;
      else if (e[4] && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end else if (err_clr) m_cnt = 4'd0;
    prev_stall = u_if.out_valid && !u_if.out_ready;
    held = obs_fields();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] v);
    u_if.in_valid  = 1'b1;
    u_if.in_onehot = v;
    cycle();
  endtask

  task automatic drain();
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 20 && (q_exp.size() != 0 || u_if.out_valid); i++) cycle();
    check("drain_empty", q_exp.size(), 0);
  endtask

  initial begin
    logic [15:0] v;
    int          sent;
    rst = 1'b1;
    err_clr = 1'b0;
    err_clr1 = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_onehot = '0;
    u_if.out_ready = 1'b1;
    u_if1.in_valid = 1'b0;
    u_if1.in_onehot = '0;
    u_if1.out_ready = 1'b1;
    m_cnt = '0;
    acc = 1'b0;
    prev_stall = 1'b0;
    held = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", u_if.out_valid, 0);
    check("rst_out_bin", u_if.out_bin, 0);
    check("rst_out_err", {u_if.out_err, u_if.out_zero}, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", u_if.in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", u_if.in_ready, 1);

    // Legal beats, one-cycle latency
    send(16'h0001);
    check("lat_valid", u_if.out_valid, 1);
    check("lat_bin0", u_if.out_bin, 0);
    send(16'h0400);
    check("lat_bin10", u_if.out_bin, 10);
    send(16'h8000);
    check("lat_bin15", u_if.out_bin, 15);
    check("legal_err", u_if.out_err, 0);
    drain();
    check("legal_cnt", err_cnt, 0);

    // Illegal beats
    send(16'h0000);
    check("zero_fields", obs_fields(), 6'b11_0000);
    send(16'h0120);
    check("multi_fields", obs_fields(), 6'b01_0101);
    drain();
    check("illegal_cnt", err_cnt, 2);

    // Back-pressure: hold each beat until accepted
    u_if.out_ready = 1'b0;
    send(16'h0001);
    send(16'h0002);
    u_if.in_onehot = 16'h0004;
    #1;
    check("bp_in_ready_low", u_if.in_ready, 0);
    cycle();
    check("bp_in_ready_still_low", u_if.in_ready, 0);
    check("bp_held_bin", u_if.out_bin, 0);
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 10 && !acc; i++) send(16'h0004);
    for (int i = 0, a = 0; i < 10 && a == 0; i++) begin
      send(16'h0008);
      a = acc ? 1 : 0;
    end
    drain();

    // Counter saturation at 15, then clear coinciding with an errored accept
    for (int i = 0; i < 20; i++) send((i % 2 == 0) ? 16'h0000 : 16'h0003);
    drain();
    check("cnt_sat", err_cnt, 15);
    check("cnt_model_sat", err_cnt, m_cnt);
    err_clr = 1'b1;
    send(16'h0000);
    err_clr = 1'b0;
    u_if.in_valid = 1'b0;
    #1;
    check("cnt_clr_with_err", err_cnt, 1);
    drain();

    // Reset mid-stream with two beats held
    u_if.out_ready = 1'b0;
    send(16'h0000);
    send(16'h0010);
    u_if.in_valid = 1'b0;
    check("pre_rst_valid", u_if.out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", u_if.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_exp.delete();
    m_cnt = '0;
    prev_stall = 1'b0;
    #1;
    check("rst_mid_out_valid", u_if.out_valid, 0);
    check("rst_mid_err_cnt", err_cnt, 0);
    check("rst_mid_in_ready_after", u_if.in_ready, 1);

    // Random stall stress
    sent = 0;
    u_if.in_valid = 1'b0;
    for (int it = 0; it < 20000 && sent < 1000; it++) begin
      if (!u_if.in_valid || acc) begin
        if ($urandom_range(0, 9) < 7) begin
          v = ($urandom_range(0, 4) != 0) ? (16'h1 << $urandom_range(0, 15)) : 16'($urandom);
          u_if.in_valid  = 1'b1;
          u_if.in_onehot = v;
        end else u_if.in_valid = 1'b0;
      end
      u_if.out_ready = ($urandom_range(0, 9) < 6);
      err_clr = ($urandom_range(0, 19) == 0);
      cycle();
      if (acc) sent++;
      if (sent == 1000) u_if.in_valid = 1'b0;
    end
    err_clr = 1'b0;
    check("stress_sent", sent, 1000);
    drain();
    check("stress_cnt", err_cnt, m_cnt);

    // Single-bit width instance
    u_if1.in_valid = 1'b1;
    u_if1.in_onehot = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("w1_legal", {u_if1.out_valid, u_if1.out_zero, u_if1.out_err, u_if1.out_bin}, 4'b1000);
    u_if1.in_onehot = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w1_zero", {u_if1.out_valid, u_if1.out_zero, u_if1.out_err, u_if1.out_bin}, 4'b1110);
    u_if1.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w1_cnt", err_cnt1, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
